// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizing for the CDB arbiter and its result FIFOs.
package cdb_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_ID_W       = 5;
  localparam int EX_UNITS       = 4;
  localparam int N_CDB          = 2;
  localparam int CDB_FIFO_DEPTH = 2;

  // One broadcast slot as seen by the ROB and reservation stations.
  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] rob_id;
    logic [XLEN-1:0]     rd_data;
  } cdb_t;

  // Index width that stays at least 1 bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit result buses in, CDB broadcast slots out.
interface cdb_arbiter_if #(
  parameter int N_EXEC   = cdb_arbiter_pkg::EX_UNITS,
  parameter int N_CDB    = cdb_arbiter_pkg::N_CDB,
  parameter int ROB_ID_W = cdb_arbiter_pkg::ROB_ID_W,
  parameter int SRC_W    = cdb_arbiter_pkg::idx_w(N_EXEC)
);
  import cdb_arbiter_pkg::*;

  logic [N_EXEC-1:0]                ex_valid;
  logic [N_EXEC-1:0][ROB_ID_W-1:0]  ex_rob_id;
  logic [N_EXEC-1:0][XLEN-1:0]      ex_data;
  logic [N_EXEC-1:0]                ex_stall;

  logic [N_CDB-1:0]                 cdb_valid;
  logic [N_CDB-1:0][ROB_ID_W-1:0]   cdb_rob_id;
  logic [N_CDB-1:0][XLEN-1:0]       cdb_data;
  logic [N_CDB-1:0][SRC_W-1:0]      cdb_src;
  cdb_t [N_CDB-1:0]                 cdb;

  // Execution side: produces results, observes stall and the bus.
  modport master (
    output ex_valid, ex_rob_id, ex_data,
    input  ex_stall, cdb_valid, cdb_rob_id, cdb_data, cdb_src, cdb
  );

  // Arbiter side.
  modport slave (
    input  ex_valid, ex_rob_id, ex_data,
    output ex_stall, cdb_valid, cdb_rob_id, cdb_data, cdb_src, cdb
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Single-push/single-pop result FIFO with synchronous clear.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [PW:0]             r_count;
  logic                    w_push;
  logic                    w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (PW+1)'(DEPTH));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_head];

  // Storage is data-only; validity lives in r_count so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !clr) r_mem[r_tail] <= din;
  end

  // Pointers wrap naturally; a concurrent push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers per-unit results and broadcasts up to N_CDB of them per cycle,
// round-robin across units starting at r_rr.
module cdb_arbiter #(
  parameter int N_EXEC     = cdb_arbiter_pkg::EX_UNITS,
  parameter int N_CDB      = cdb_arbiter_pkg::N_CDB,
  parameter int FIFO_DEPTH = cdb_arbiter_pkg::CDB_FIFO_DEPTH,
  parameter int ROB_ID_W   = cdb_arbiter_pkg::ROB_ID_W,
  parameter int SRC_W      = cdb_arbiter_pkg::idx_w(N_EXEC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  import cdb_arbiter_pkg::*;

  localparam int ENT_W = ROB_ID_W + XLEN;

  logic                           w_kill;
  logic [N_EXEC-1:0]              w_push;
  logic [N_EXEC-1:0]              w_pop;
  logic [N_EXEC-1:0]              w_empty;
  logic [N_EXEC-1:0]              w_full;
  logic [N_EXEC-1:0][ENT_W-1:0]   w_din;
  logic [N_EXEC-1:0][ENT_W-1:0]   w_head;
  logic [SRC_W-1:0]               r_rr;
  logic [SRC_W-1:0]               w_last;
  logic                           w_any;
  logic [N_CDB-1:0]               w_slot_vld;
  logic [N_CDB-1:0][SRC_W-1:0]    w_slot_src;

  // Flush and reset both kill the bus and drop pushes in the same cycle.
  assign w_kill = rst | flush;

  // Stall follows the registered count only, so no arbitration-to-stall path.
  assign bus.ex_stall = w_full & {N_EXEC{~rst}};

  for (genvar g = 0; g < N_EXEC; g++) begin : g_unit
    assign w_din[g]  = {bus.ex_rob_id[g], bus.ex_data[g]};
    assign w_push[g] = bus.ex_valid[g] & ~w_full[g] & ~w_kill;

    result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .din   (w_din[g]),
      .dout  (w_head[g]),
      .empty (w_empty[g]),
      .full  (w_full[g])
    );
  end

  // Rotating scan from r_rr; the k-th non-empty unit found lands in slot k.
  always_comb begin
    int               n_grant;
    int               idx;
    logic [SRC_W-1:0] u;
    w_pop      = '0;
    w_slot_vld = '0;
    w_slot_src = '0;
    w_any      = 1'b0;
    w_last     = r_rr;
    n_grant    = 0;
    idx        = 0;
    u          = '0;
    for (int j = 0; j < N_EXEC; j++) begin
      idx = int'(r_rr) + j;
      if (idx >= N_EXEC) idx = idx - N_EXEC;
      u = SRC_W'(idx);
      if (!w_kill && !w_empty[u] && n_grant < N_CDB) begin
        w_pop[u] = 1'b1;
        for (int k = 0; k < N_CDB; k++) begin
          if (n_grant == k) begin
            w_slot_vld[k] = 1'b1;
            w_slot_src[k] = u;
          end
        end
        w_last  = u;
        w_any   = 1'b1;
        n_grant = n_grant + 1;
      end
    end
  end

  // Heads go straight to the bus; idle slots are held at zero.
  always_comb begin
    bus.cdb_valid  = '0;
    bus.cdb_rob_id = '0;
    bus.cdb_data   = '0;
    bus.cdb_src    = '0;
    bus.cdb        = '0;
    for (int k = 0; k < N_CDB; k++) begin
      if (w_slot_vld[k]) begin
        bus.cdb_valid[k]      = 1'b1;
        bus.cdb_rob_id[k]     = w_head[w_slot_src[k]][XLEN +: ROB_ID_W];
        bus.cdb_data[k]       = w_head[w_slot_src[k]][XLEN-1:0];
        bus.cdb_src[k]        = w_slot_src[k];
        bus.cdb[k].valid      = 1'b1;
        bus.cdb[k].rob_id     = w_head[w_slot_src[k]][XLEN +: ROB_ID_W];
        bus.cdb[k].rd_data    = w_head[w_slot_src[k]][XLEN-1:0];
      end
    end
  end

  // Next scan starts just past the last unit granted; holds when idle.
  always_ff @(posedge clk) begin
    if (w_kill)
      r_rr <= '0;
    else if (w_any)
      r_rr <= (w_last == SRC_W'(N_EXEC-1)) ? '0 : w_last + 1'b1;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-unit expected-result queues filled on accepted
// pushes and drained as the CDB broadcasts, plus directed scenario checks.
module tb_cdb_arbiter;
  localparam int N_EXEC = 4;
  localparam int N_CDB  = 2;
  localparam int DEPTH  = 2;

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ent_t mq [N_EXEC][$];
  int   rr;
  int   n_chk;
  int   n_err;
  logic saw_stall0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one cycle, evaluated mid-cycle on stable inputs.
  task automatic model_step();
    bit   full [N_EXEC];
    int   src  [N_CDB];
    int   ng;
    int   u;
    ent_t e;
    cdb_arbiter_pkg::cdb_t xc;
    ng = 0;
    for (int i = 0; i < N_EXEC; i++) begin
      full[i] = (mq[i].size() == DEPTH);
      chk($sformatf("stall%0d", i), 64'(bus.ex_stall[i]), 64'((full[i] && !rst) ? 1 : 0));
    end
    if (!rst && !flush) begin
      for (int j = 0; j < N_EXEC; j++) begin
        u = (rr + j) % N_EXEC;
        if (mq[u].size() != 0 && ng < N_CDB) begin
          src[ng] = u;
          ng++;
        end
      end
    end
    for (int k = 0; k < N_CDB; k++) begin
      if (k < ng) begin
        e = mq[src[k]].pop_front();
        chk($sformatf("slot%0d", k),
            64'({bus.cdb_valid[k], bus.cdb_src[k], bus.cdb_rob_id[k], bus.cdb_data[k]}),
            64'({1'b1, 2'(src[k]), e.rob, e.data}));
        xc = '{valid: 1'b1, rob_id: e.rob, rd_data: e.data};
      end else begin
        chk($sformatf("idle%0d", k),
            64'({bus.cdb_valid[k], bus.cdb_src[k], bus.cdb_rob_id[k], bus.cdb_data[k]}), 64'(0));
        xc = '0;
      end
      chk($sformatf("cdbt%0d", k), 64'(bus.cdb[k]), 64'(xc));
    end
    if (rst || flush) begin
      for (int i = 0; i < N_EXEC; i++) mq[i].delete();
      rr = 0;
    end else begin
      if (ng > 0) rr = (src[ng-1] + 1) % N_EXEC;
      for (int i = 0; i < N_EXEC; i++)
        if (bus.ex_valid[i] && !full[i])
          mq[i].push_back('{bus.ex_rob_id[i], bus.ex_data[i]});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    if (bus.ex_stall[0]) saw_stall0 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid  = '0;
    bus.ex_rob_id = '0;
    bus.ex_data   = '0;
  endtask

  task automatic put(input int u, input logic [4:0] rob, input logic [31:0] d);
    bus.ex_valid[u]  = 1'b1;
    bus.ex_rob_id[u] = rob;
    bus.ex_data[u]   = d;
  endtask

  // Behaves like an RS: a stalled entry is held, otherwise a fresh one is offered.
  task automatic rs_drive(input logic [N_EXEC-1:0] mask);
    for (int i = 0; i < N_EXEC; i++) begin
      if (mask[i]) begin
        if (!(bus.ex_valid[i] && bus.ex_stall[i])) put(i, 5'($urandom), $urandom);
      end else begin
        bus.ex_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; rr = 0; saw_stall0 = 1'b0;
    idle();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    // Single result from unit 2.
    put(2, 5'd5, 32'hDEADBEEF);
    cycle();
    idle();
    chk("t1_valid", 64'(bus.cdb_valid), 64'(2'b01));
    chk("t1_rob",   64'(bus.cdb_rob_id[0]), 64'(5));
    chk("t1_data",  64'(bus.cdb_data[0]), 64'h DEADBEEF);
    chk("t1_src",   64'(bus.cdb_src[0]), 64'(2));
    cycle();
    // Pointer now at 3: unit 3 must beat unit 0.
    put(0, 5'd8, 32'h8);
    put(3, 5'd9, 32'h9);
    cycle();
    idle();
    chk("t1_rr_s0", 64'(bus.cdb_src[0]), 64'(3));
    chk("t1_rr_s1", 64'(bus.cdb_src[1]), 64'(0));
    cycle();
    put(3, 5'd10, 32'hA);
    cycle();
    idle();
    cycle();

    // Over-subscription from pointer 0.
    for (int i = 0; i < N_EXEC; i++) put(i, 5'(i + 1), 32'h100 + i);
    cycle();
    idle();
    chk("t2a_valid", 64'(bus.cdb_valid), 64'(2'b11));
    chk("t2a_rob",   64'({bus.cdb_rob_id[0], bus.cdb_rob_id[1]}), 64'({5'd1, 5'd2}));
    cycle();
    chk("t2b_rob",   64'({bus.cdb_rob_id[0], bus.cdb_rob_id[1]}), 64'({5'd3, 5'd4}));
    cycle();
    chk("t2c_valid", 64'(bus.cdb_valid), 64'(0));
    cycle();

    // All units pushing continuously overruns the two slots and forces stalls.
    repeat (20) begin rs_drive(4'b1111); cycle(); end
    idle();
    repeat (6) cycle();
    chk("t3_stall_seen", 64'(saw_stall0), 64'(1));

    // Two continuous requesters.
    repeat (16) begin rs_drive(4'b1001); cycle(); end
    idle();
    repeat (4) cycle();

    // Flush with three buffered results and a concurrent push.
    put(0, 5'd20, 32'h20); put(1, 5'd21, 32'h21); put(2, 5'd22, 32'h22);
    cycle();
    idle();
    flush = 1'b1;
    put(3, 5'd23, 32'h23);
    #1;
    chk("t5_flush_valid", 64'(bus.cdb_valid), 64'(0));
    cycle();
    flush = 1'b0;
    idle();
    #1;
    chk("t5_post_valid", 64'(bus.cdb_valid), 64'(0));
    chk("t5_post_stall", 64'(bus.ex_stall), 64'(0));
    repeat (3) cycle();

    // Reset with full FIFOs, then a fresh result.
    repeat (5) begin rs_drive(4'b1111); cycle(); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle();
    #1;
    chk("t6_valid", 64'(bus.cdb_valid), 64'(0));
    chk("t6_stall", 64'(bus.ex_stall), 64'(0));
    chk("t6_bus",   64'({bus.cdb_rob_id, bus.cdb_src}), 64'(0));
    put(0, 5'd7, 32'h1);
    cycle();
    idle();
    chk("t6_new", 64'({bus.cdb_valid[0], bus.cdb_rob_id[0], bus.cdb_data[0], bus.cdb_src[0]}),
                  64'({1'b1, 5'd7, 32'h1, 2'd0}));
    cycle();

    // Mixed random traffic with occasional flushes.
    repeat (400) begin
      rs_drive(4'($urandom));
      flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    idle();
    repeat (6) cycle();
    for (int i = 0; i < N_EXEC; i++)
      chk($sformatf("drained%0d", i), 64'(mq[i].size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
